// File: rtl/fifo_uart_pkg.sv
// ============================================================================
// Module  : fifo_uart_pkg
// Brief   : Shared state encodings, ASCII constants and helpers for the
//           FIFO-to-UART hex dump path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_uart_pkg;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_POP  = 2'd1,
        CTL_WAIT = 2'd2,
        CTL_SEND = 2'd3
    } ctl_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n <= 4'd9) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_hex_uart_tx_if.sv
// ============================================================================
// Module  : fifo_hex_uart_tx_if
// Brief   : FIFO read-port bundle; master pops, slave is the FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_hex_uart_tx_if;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [3:0] fifo_rd_data;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_rd_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_rd_data
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_8n1.sv
// ============================================================================
// Module  : uart_tx_8n1
// Brief   : 8N1 serializer with baud counter; accepts a byte on i_load when
//           o_ready, including back-to-back at the final stop-bit cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_8n1
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_load,
    input  wire logic [7:0] i_data,
    output logic            o_ready,
    output logic            o_frame_end,
    output logic            o_tx
);

    localparam int             c_cnt_w   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);

    tx_state_t          r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_tx, w_tx_nxt;
    logic               w_cnt_zero;

    assign w_cnt_zero  = (r_cnt == '0);
    assign o_frame_end = (r_state == TX_STOP) && w_cnt_zero;
    assign o_ready     = (r_state == TX_IDLE) || o_frame_end;
    assign o_tx        = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        case (r_state)
            TX_IDLE: begin
                w_cnt_nxt = '0;
                if (i_load) begin
                    w_state_nxt = TX_START;
                    w_cnt_nxt   = c_cnt_max;
                    w_shift_nxt = i_data;
                    w_tx_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (w_cnt_zero) begin
                    w_state_nxt   = TX_DATA;
                    w_cnt_nxt     = c_cnt_max;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            TX_DATA: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt = c_cnt_max;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = TX_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // Shift right so the next data bit is always at index 1
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (w_cnt_zero) begin
                    if (i_load) begin
                        w_state_nxt = TX_START;
                        w_cnt_nxt   = c_cnt_max;
                        w_shift_nxt = i_data;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = TX_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fifo_hex_uart_tx.sv
// ============================================================================
// Module  : fifo_hex_uart_tx
// Brief   : Pops nibbles from a FIFO and sends them as ASCII hex over UART,
//           optionally followed by CR+LF.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_hex_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int APPEND_CRLF = 0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              enable,
    fifo_hex_uart_tx_if.master     fifo,
    output logic                   tx,
    output logic                   busy
);

    localparam int c_clks_per_bit = clks_per_bit(CLK_FREQ_HZ, BAUD);

    ctl_state_t r_state, w_state_nxt;
    logic       r_rd_en, w_rd_en_nxt;
    logic       r_busy, w_busy_nxt;
    logic [1:0] r_crlf_idx, w_crlf_idx_nxt;
    logic       w_load;
    logic [7:0] w_char;
    logic       w_tx_ready;
    logic       w_frame_end;

    assign fifo.fifo_rd_en = r_rd_en;
    assign busy            = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CTL_IDLE;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_crlf_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_busy     <= w_busy_nxt;
            r_crlf_idx <= w_crlf_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rd_en_nxt    = 1'b0;
        w_busy_nxt     = r_busy;
        w_crlf_idx_nxt = r_crlf_idx;
        w_load         = 1'b0;
        w_char         = 8'h00;
        case (r_state)
            CTL_IDLE: begin
                if (enable && !fifo.fifo_empty) begin
                    w_state_nxt = CTL_POP;
                    w_rd_en_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            CTL_POP: begin
                w_state_nxt = CTL_WAIT;
            end
            CTL_WAIT: begin
                // FIFO data has one cycle of read latency; it is valid now
                if (w_tx_ready) begin
                    w_load         = 1'b1;
                    w_char         = nibble_to_ascii(fifo.fifo_rd_data);
                    w_crlf_idx_nxt = '0;
                    w_state_nxt    = CTL_SEND;
                end
            end
            CTL_SEND: begin
                if (w_frame_end) begin
                    if ((APPEND_CRLF != 0) && (r_crlf_idx != 2'd2)) begin
                        w_load         = 1'b1;
                        w_char         = (r_crlf_idx == 2'd0) ? ASCII_CR : ASCII_LF;
                        w_crlf_idx_nxt = r_crlf_idx + 2'd1;
                    end else begin
                        w_state_nxt = CTL_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = CTL_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_uart_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_data      (w_char),
        .o_ready     (w_tx_ready),
        .o_frame_end (w_frame_end),
        .o_tx        (tx)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_hex_uart_tx.sv
// ============================================================================
// Module  : tb_fifo_hex_uart_tx
// Brief   : Directed bench; dut0 without CR/LF, dut1 with CR/LF, each fed by a
//           small FIFO model with one cycle of read latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_hex_uart_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en0 = 1'b0;
    logic en1 = 1'b0;
    logic tx0, tx1, busy0, busy1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [3:0] mem0 [16];
    logic [3:0] mem1 [16];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    int pops0 = 0, pops1 = 0, viol = 0;

    fifo_hex_uart_tx_if f0();
    fifo_hex_uart_tx_if f1();

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fifo_hex_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .APPEND_CRLF(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .fifo(f0), .tx(tx0), .busy(busy0)
    );
    fifo_hex_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .APPEND_CRLF(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .fifo(f1), .tx(tx1), .busy(busy1)
    );

    assign f0.fifo_empty = (wp0 == rp0);
    assign f1.fifo_empty = (wp1 == rp1);

    always @(posedge clk) begin
        if (f0.fifo_rd_en) begin
            if (wp0 == rp0) viol++;
            else begin
                f0.fifo_rd_data <= mem0[rp0 % 16];
                rp0 <= rp0 + 1;
                pops0++;
            end
        end
        if (f1.fifo_rd_en) begin
            if (wp1 == rp1) viol++;
            else begin
                f1.fifo_rd_data <= mem1[rp1 % 16];
                rp1 <= rp1 + 1;
                pops1++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic txs(input int s);
        return (s != 0) ? tx1 : tx0;
    endfunction

    task automatic push(input int s, input logic [3:0] n);
        if (s != 0) begin mem1[wp1 % 16] = n; wp1++; end
        else        begin mem0[wp0 % 16] = n; wp0++; end
    endtask

    // Leaves the caller at the first falling-edge sample showing the start bit
    task automatic wait_start(input int s, input string tag);
        for (int i = 0; i < 300 && txs(s) !== 1'b0; i++) @(negedge clk);
        chk(tag, {31'd0, txs(s)}, 32'd0);
    endtask

    // Samples start, data and stop bits at their centres; ends at stop centre
    task automatic collect(input int s, input string tag, output logic [7:0] b);
        repeat (4) @(negedge clk);
        chk({tag, "_start"}, {31'd0, txs(s)}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = txs(s);
        end
        repeat (10) @(negedge clk);
        chk({tag, "_stop"}, {31'd0, txs(s)}, 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        int bad;
        int s0, s1, s2;
        logic [7:0] exp4 [3];
        exp4[0] = 8'h30; exp4[1] = 8'h39; exp4[2] = 8'h46;

        // Test 1: reset and idle with empty FIFOs
        en0 = 1'b1; en1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_rst_tx0", {31'd0, tx0}, 32'd1);
        chk("t1_rst_busy0", {31'd0, busy0}, 32'd0);
        chk("t1_rst_rd_en0", {31'd0, f0.fifo_rd_en}, 32'd0);
        chk("t1_rst_tx1", {31'd0, tx1}, 32'd1);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        chk("t1_idle", bad, 0);
        chk("t1_no_pop", pops0 + pops1 + viol, 0);

        // Test 2: single 'A' (0x41), exact pop/start/busy timing
        push(0, 4'hA);
        for (int i = 0; i < 20 && f0.fifo_rd_en !== 1'b1; i++) @(negedge clk);
        chk("t2_rd_en", {31'd0, f0.fifo_rd_en}, 32'd1);
        chk("t2_busy_pop", {31'd0, busy0}, 32'd1);
        chk("t2_tx_pop", {31'd0, tx0}, 32'd1);
        @(negedge clk);
        chk("t2_rd_en_1cyc", {31'd0, f0.fifo_rd_en}, 32'd0);
        chk("t2_tx_wait", {31'd0, tx0}, 32'd1);
        @(negedge clk);
        chk("t2_tx_start_k2", {31'd0, tx0}, 32'd0);
        collect(0, "t2", b);
        chk("t2_char", {24'd0, b}, 32'h41);
        repeat (5) @(negedge clk);
        chk("t2_busy_last", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        chk("t2_busy_low", {31'd0, busy0}, 32'd0);
        chk("t2_pops", pops0, 1);

        // Test 3: '3' with CR/LF, three back-to-back frames, one pop
        push(1, 4'h3);
        wait_start(1, "t3_s0"); s0 = cyc;
        collect(1, "t3_c0", b);
        chk("t3_char0", {24'd0, b}, 32'h33);
        wait_start(1, "t3_s1"); s1 = cyc;
        collect(1, "t3_c1", b);
        chk("t3_char1", {24'd0, b}, 32'h0D);
        chk("t3_gap1", s1 - s0, 100);
        wait_start(1, "t3_s2"); s2 = cyc;
        collect(1, "t3_c2", b);
        chk("t3_char2", {24'd0, b}, 32'h0A);
        chk("t3_gap2", s2 - s1, 100);
        chk("t3_busy_mid", {31'd0, busy1}, 32'd1);
        repeat (6) @(negedge clk);
        chk("t3_busy_end", {31'd0, busy1}, 32'd0);
        chk("t3_pops", pops1, 1);

        // Test 4: "09F", each pop only after the prior frame
        push(0, 4'h0); push(0, 4'h9); push(0, 4'hF);
        for (int j = 0; j < 3; j++) begin
            wait_start(0, "t4_start");
            collect(0, "t4", b);
            chk("t4_char", {24'd0, b}, {24'd0, exp4[j]});
            chk("t4_pops", pops0, 2 + j);
        end
        repeat (10) @(negedge clk);

        // Test 5: async reset during data bit 3 of '5' (0x35)
        push(0, 4'h5);
        wait_start(0, "t5_start");
        repeat (44) @(negedge clk);
        chk("t5_bit3", {31'd0, tx0}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", {31'd0, tx0}, 32'd1);
        chk("t5_rst_busy", {31'd0, busy0}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        chk("t5_idle", bad, 0);
        chk("t5_pops", pops0, 5);

        // Test 6: enable drop mid-frame holds off the next pop
        push(0, 4'h7); push(0, 4'h8);
        wait_start(0, "t6_start0");
        en0 = 1'b0;
        collect(0, "t6_c0", b);
        chk("t6_char0", {24'd0, b}, 32'h37);
        repeat (10) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        chk("t6_hold", bad, 0);
        chk("t6_pops_hold", pops0, 6);
        en0 = 1'b1;
        wait_start(0, "t6_start1");
        collect(0, "t6_c1", b);
        chk("t6_char1", {24'd0, b}, 32'h38);
        chk("t6_pops", pops0, 7);
        chk("rd_en_when_empty", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
